ucie_ctl_csr_regfile: RTL



---
 rtl/ucie_ctl_csr_pkg.sv | 41 ++++
 rtl/ucie_ctl_csr_retrain_ctl.sv | 62 ++++++
 rtl/ucie_ctl_csr_regfile.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ucie_ctl_csr_pkg.sv
// Shared constants for the UCIe adapter CSR register file: address map, reset values, retrain FSM encoding.
// Optional CORR_CNT register at 0x1C is mapped only when UCIE_CSR_ERR_CNT_EN is defined.
package ucie_ctl_csr_pkg;

  localparam logic [7:0] ADDR_ADVCAP     = 8'h00;
  localparam logic [7:0] ADDR_LINK_CTRL  = 8'h04;
  localparam logic [7:0] ADDR_LINK_STS   = 8'h08;
  localparam logic [7:0] ADDR_UNCORR_STS = 8'h0C;
  localparam logic [7:0] ADDR_CORR_STS   = 8'h10;
  localparam logic [7:0] ADDR_HDR_LOG    = 8'h14;
  localparam logic [7:0] ADDR_ERR_MASK   = 8'h18;
  localparam logic [7:0] ADDR_CORR_CNT   = 8'h1C;

  localparam logic [31:0] ADVCAP_RST_DEF = 32'h0000_0001;
  localparam logic [31:0] ERR_MASK_RST   = 32'hFFFF_FFFF;

  localparam int RETRAIN_BIT = 0;
  localparam int TO_BIT      = 31;

  typedef enum logic [1:0] {
    RT_IDLE      = 2'd0,
    RT_REQ       = 2'd1,
    RT_WAIT_EXIT = 2'd2
  } rt_state_e;

  function automatic logic is_mapped(input logic [7:0] a);
    logic m;
    m = (a == ADDR_ADVCAP) || (a == ADDR_LINK_CTRL) || (a == ADDR_LINK_STS) ||
        (a == ADDR_UNCORR_STS) || (a == ADDR_CORR_STS) || (a == ADDR_HDR_LOG) ||
        (a == ADDR_ERR_MASK);
`ifdef UCIE_CSR_ERR_CNT_EN
    m = m || (a == ADDR_CORR_CNT);
`endif
    return m;
  endfunction

  function automatic logic is_host_ro(input logic [7:0] a);
    return (a == ADDR_LINK_STS) || (a == ADDR_HDR_LOG);
  endfunction

endpackage

// File: rtl/ucie_ctl_csr_retrain_ctl.sv
// Retrain request handshake: holds the request until the controller acks or the timeout expires.
module ucie_ctl_csr_retrain_ctl
  import ucie_ctl_csr_pkg::*;
#(
  parameter int RETRAIN_TIMEOUT = 1024,
  parameter int TO_W            = 11
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_ack,
  output logic o_req,
  output logic o_timeout
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RETRAIN_TIMEOUT - 1);

  rt_state_e       r_state, w_state_nxt;
  logic [TO_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RT_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_timeout   = 1'b0;
    case (r_state)
      RT_IDLE: begin
        if (i_start) begin
          w_state_nxt = RT_REQ;
          w_cnt_nxt   = '0;
        end
      end
      RT_REQ: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (i_ack) begin
          w_state_nxt = RT_WAIT_EXIT;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = RT_IDLE;
          o_timeout   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RT_WAIT_EXIT: begin
        if (!i_ack) w_state_nxt = RT_IDLE;
      end
      default: w_state_nxt = RT_IDLE;
    endcase
  end

  assign o_req = (r_state == RT_REQ);

endmodule

// File: rtl/ucie_ctl_csr_regfile.sv
// UCIe adapter CSR register file: logging write port, host RW/RW1C port, irq and retrain handshake.
// Define UCIE_CSR_ERR_CNT_EN to add the 16-bit saturating CORR_CNT register at 0x1C.
module ucie_ctl_csr_regfile
  import ucie_ctl_csr_pkg::*;
#(
  parameter logic [31:0] ADVCAP_RST      = ADVCAP_RST_DEF,
  parameter int          RETRAIN_TIMEOUT = 1024,
  parameter int          TO_W            = 11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_csr_wr,
  input  logic [7:0]  i_csr_addr,
  input  logic [31:0] i_csr_wdata,
  input  logic        i_retrain_ack,
  input  logic        i_host_wr,
  input  logic        i_host_rd,
  input  logic [7:0]  i_host_addr,
  input  logic [31:0] i_host_wdata,
  output logic [31:0] o_host_rdata,
  output logic        o_host_rvalid,
  output logic        o_host_err,
  output logic [31:0] o_csr_ADVCAP,
  output logic        o_csr_UCIe_Link_Control_Retrain,
  output logic        o_irq
);

  logic [31:0] r_advcap, r_link_sts, r_uncorr, r_corr, r_hdr_log, r_err_mask;
  logic [31:1] r_link_scratch;
  logic [31:0] r_rdata;
  logic        r_rvalid, r_err, r_irq;

  logic        w_hwr, w_hrd, w_conflict, w_mapped, w_ro, w_wr_ok, w_err;
  logic        w_we_advcap, w_we_link, w_we_uncorr, w_we_corr, w_we_mask;
  logic        w_lw_link_sts, w_lw_uncorr, w_lw_corr, w_lw_hdr;
  logic        w_req, w_timeout, w_rt_start;
  logic [31:0] w_to_set, w_uncorr_nxt, w_corr_nxt, w_rdata;

  // Simultaneous read and write is an error and neither side is performed.
  assign w_conflict = i_host_wr & i_host_rd;
  assign w_hwr      = i_host_wr & ~i_host_rd;
  assign w_hrd      = i_host_rd & ~i_host_wr;
  assign w_mapped   = is_mapped(i_host_addr);
  assign w_ro       = is_host_ro(i_host_addr);
  assign w_wr_ok    = w_hwr & w_mapped & ~w_ro;
  assign w_err      = w_conflict | (w_hwr & (~w_mapped | w_ro)) | (w_hrd & ~w_mapped);

  assign w_we_advcap = w_wr_ok & (i_host_addr == ADDR_ADVCAP);
  assign w_we_link   = w_wr_ok & (i_host_addr == ADDR_LINK_CTRL);
  assign w_we_uncorr = w_wr_ok & (i_host_addr == ADDR_UNCORR_STS);
  assign w_we_corr   = w_wr_ok & (i_host_addr == ADDR_CORR_STS);
  assign w_we_mask   = w_wr_ok & (i_host_addr == ADDR_ERR_MASK);

  assign w_lw_link_sts = i_csr_wr & (i_csr_addr == ADDR_LINK_STS);
  assign w_lw_uncorr   = i_csr_wr & (i_csr_addr == ADDR_UNCORR_STS);
  assign w_lw_corr     = i_csr_wr & (i_csr_addr == ADDR_CORR_STS);
  assign w_lw_hdr      = i_csr_wr & (i_csr_addr == ADDR_HDR_LOG);

  assign w_rt_start = w_we_link & i_host_wdata[RETRAIN_BIT];

  ucie_ctl_csr_retrain_ctl #(
    .RETRAIN_TIMEOUT(RETRAIN_TIMEOUT),
    .TO_W           (TO_W)
  ) u_retrain (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_rt_start),
    .i_ack    (i_retrain_ack),
    .o_req    (w_req),
    .o_timeout(w_timeout)
  );

  always_comb begin
    w_to_set         = '0;
    w_to_set[TO_BIT] = w_timeout;
  end

  // Set sources are ORed in after the RW1C clear so a racing set survives.
  assign w_uncorr_nxt = (r_uncorr & ~(w_we_uncorr ? i_host_wdata : 32'h0))
                      | (w_lw_uncorr ? i_csr_wdata : 32'h0) | w_to_set;
  assign w_corr_nxt   = (r_corr & ~(w_we_corr ? i_host_wdata : 32'h0))
                      | (w_lw_corr ? i_csr_wdata : 32'h0);

`ifdef UCIE_CSR_ERR_CNT_EN
  logic [15:0] r_corr_cnt;
  logic        w_we_cnt;

  assign w_we_cnt = w_wr_ok & (i_host_addr == ADDR_CORR_CNT);

  always_ff @(posedge i_clk) begin
    if (i_rst)                                                     r_corr_cnt <= '0;
    else if (w_we_cnt)                                             r_corr_cnt <= '0;
    else if (w_lw_corr && (|i_csr_wdata) && (r_corr_cnt != 16'hFFFF)) r_corr_cnt <= r_corr_cnt + 16'd1;
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (i_host_addr)
      ADDR_ADVCAP:     w_rdata = r_advcap;
      ADDR_LINK_CTRL:  w_rdata = {r_link_scratch, w_req};
      ADDR_LINK_STS:   w_rdata = r_link_sts;
      ADDR_UNCORR_STS: w_rdata = r_uncorr;
      ADDR_CORR_STS:   w_rdata = r_corr;
      ADDR_HDR_LOG:    w_rdata = r_hdr_log;
      ADDR_ERR_MASK:   w_rdata = r_err_mask;
`ifdef UCIE_CSR_ERR_CNT_EN
      ADDR_CORR_CNT:   w_rdata = {16'h0, r_corr_cnt};
`endif
      default:         w_rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_advcap       <= ADVCAP_RST;
      r_link_scratch <= '0;
      r_link_sts     <= '0;
      r_uncorr       <= '0;
      r_corr         <= '0;
      r_hdr_log      <= '0;
      r_err_mask     <= ERR_MASK_RST;
      r_rdata        <= '0;
      r_rvalid       <= 1'b0;
      r_err          <= 1'b0;
      r_irq          <= 1'b0;
    end else begin
      if (w_we_advcap)   r_advcap       <= i_host_wdata;
      if (w_we_link)     r_link_scratch <= i_host_wdata[31:1];
      if (w_lw_link_sts) r_link_sts     <= i_csr_wdata;
      if (w_lw_hdr)      r_hdr_log      <= i_csr_wdata;
      if (w_we_mask)     r_err_mask     <= i_host_wdata;
      r_uncorr <= w_uncorr_nxt;
      r_corr   <= w_corr_nxt;
      r_rvalid <= w_hrd;
      if (w_hrd) r_rdata <= w_rdata;
      r_err    <= w_err;
      r_irq    <= |((r_uncorr | r_corr) & ~r_err_mask);
    end
  end

  assign o_host_rdata                    = r_rdata;
  assign o_host_rvalid                   = r_rvalid;
  assign o_host_err                      = r_err;
  assign o_csr_ADVCAP                    = r_advcap;
  assign o_csr_UCIe_Link_Control_Retrain = w_req;
  assign o_irq                           = r_irq;

endmodule
